// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC sequencer: state encoding,
// counter width, iteration bound and mode encoding.
package cordic_pkg;

    localparam int CNT_W     = 3;
    localparam int ITERS_MAX = 8;

    localparam logic ROTATE = 1'b0;
    localparam logic VECTOR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Job handshake plus datapath control bundle of the CORDIC sequencer.
// master: job source / datapath side, slave: the sequencer.
interface cordic_seq_ctrl_if;
    import cordic_pkg::*;

    logic             start_valid;
    logic             start_ready;
    logic             mode;
    logic             z_sign;
    logic             y_sign;
    logic             load;
    logic [CNT_W-1:0] shift_count;
    logic [CNT_W-1:0] atan_addr;
    logic             upd_en;
    logic             sigma;
    logic             busy;
    logic             done_valid;
    logic             done_ready;

    modport master (
        output start_valid, mode, z_sign, y_sign, done_ready,
        input  start_ready, load, shift_count, atan_addr, upd_en, sigma,
               busy, done_valid
    );

    modport slave (
        input  start_valid, mode, z_sign, y_sign, done_ready,
        output start_ready, load, shift_count, atan_addr, upd_en, sigma,
               busy, done_valid
    );

endinterface

// File: rtl/cordic_seq_ctrl.sv
// Iteration sequencer for the 9-bit iterative CORDIC datapath. Each job runs
// LOAD, then ITERS SHIFT/UPDATE pairs, then holds DONE until the consumer
// takes the result. All outputs are decoded from registered state.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int ITERS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    cordic_seq_ctrl_if.slave     bus
);

    // Out-of-range builds are clamped to the range the 3-bit shift count supports.
    localparam int ITERS_C = (ITERS > ITERS_MAX) ? ITERS_MAX :
                             ((ITERS < 1) ? 1 : ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS_C - 1);

    state_e           state_r;
    logic [CNT_W-1:0] iter_r;
    logic             sigma_r;
    logic             mode_r;

    // FSM, iteration counter, sigma capture and mode latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            iter_r  <= {CNT_W{1'b0}};
            sigma_r <= 1'b0;
            mode_r  <= ROTATE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        mode_r  <= bus.mode;
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    iter_r  <= {CNT_W{1'b0}};
                    sigma_r <= 1'b0;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Rotation drives z toward zero, vectoring drives y toward zero.
                    sigma_r <= (mode_r == VECTOR) ? ~bus.y_sign : bus.z_sign;
                    state_r <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (iter_r == LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        iter_r  <= iter_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (bus.done_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state, counter and sigma.
    always_comb begin
        bus.start_ready = 1'b0;
        bus.load        = 1'b0;
        bus.shift_count = {CNT_W{1'b0}};
        bus.atan_addr   = {CNT_W{1'b0}};
        bus.upd_en      = 1'b0;
        bus.sigma       = 1'b0;
        bus.busy        = 1'b0;
        bus.done_valid  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bus.start_ready = 1'b1;
            end
            ST_LOAD: begin
                bus.load = 1'b1;
                bus.busy = 1'b1;
            end
            ST_SHIFT: begin
                bus.shift_count = iter_r;
                bus.atan_addr   = iter_r;
                bus.sigma       = sigma_r;
                bus.busy        = 1'b1;
            end
            ST_UPDATE: begin
                bus.shift_count = iter_r;
                bus.atan_addr   = iter_r;
                bus.sigma       = sigma_r;
                bus.upd_en      = 1'b1;
                bus.busy        = 1'b1;
            end
            ST_DONE: begin
                bus.busy       = 1'b1;
                bus.done_valid = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule
